decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/core_pkg.sv | 49 ++++
 rtl/decode_logic.sv | 124 ++++++++++++
 rtl/decode_stage.sv | 151 +++++++++++++++
 tb/tb_decode_stage.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode definitions: base-ISA opcodes, format codes, skid-buffer states
// and the decoded-instruction record carried through the decode stage.
package core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] FN7_ZERO = 7'b0000000;
  localparam logic [6:0] FN7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  // Immediate is kept outside the record because its width is a parameter.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] fn3;
    logic [6:0] fn7;
    fmt_e       fmt;
    logic       rs1_en;
    logic       rs2_en;
    logic       rd_we;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/decode_logic.sv
// Purely combinational base-ISA decoder: field extraction, immediate assembly
// and legality checking for one 32-bit instruction word.
module decode_logic
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RVE  = 1'b0
) (
  input  logic [31:0]     inst,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0]      opc;
  logic [6:0]      fn7;
  logic [2:0]      fn3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  fmt_e            fmt;
  logic            enc_bad;
  logic            shift_op;
  logic            rd_use;
  logic            rs1_use;
  logic            rs2_use;
  logic            rve_bad;
  logic            illegal;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign fn3 = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign fn7 = inst[31:25];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    fmt      = FMT_NONE;
    enc_bad  = 1'b0;
    shift_op = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      OPC_JALR: begin
        fmt     = FMT_I;
        enc_bad = (fn3 != 3'b000);
      end
      OPC_LOAD: begin
        fmt     = FMT_I;
        enc_bad = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
      end
      OPC_OPIMM: begin
        fmt = FMT_I;
        // Shift-immediates reuse the fn7 slot as an opcode extension.
        if (fn3 == 3'b001) begin
          shift_op = 1'b1;
          enc_bad  = (fn7 != FN7_ZERO);
        end else if (fn3 == 3'b101) begin
          shift_op = 1'b1;
          enc_bad  = (fn7 != FN7_ZERO) && (fn7 != FN7_ALT);
        end
      end
      OPC_STORE: begin
        fmt     = FMT_S;
        enc_bad = (fn3 > 3'b010);
      end
      OPC_BRANCH: begin
        fmt     = FMT_B;
        enc_bad = (fn3 == 3'b010) || (fn3 == 3'b011);
      end
      OPC_OP: begin
        fmt     = FMT_R;
        enc_bad = !((fn7 == FN7_ZERO) ||
                    ((fn7 == FN7_ALT) && ((fn3 == 3'b000) || (fn3 == 3'b101))));
      end
      default: enc_bad = 1'b1;
    endcase
  end

  assign rd_use  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  assign rs1_use = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign rs2_use = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

  assign rve_bad = RVE && ((rd_use && rd[4]) || (rs1_use && rs1[4]) || (rs2_use && rs2[4]));
  assign illegal = enc_bad || rve_bad;

  always_comb begin
    dec         = '0;
    imm         = '0;
    dec.opcode  = opc;
    dec.fmt     = FMT_NONE;
    dec.illegal = illegal;
    if (!illegal) begin
      dec.fmt    = fmt;
      dec.rd     = rd_use  ? rd  : 5'd0;
      dec.rs1    = rs1_use ? rs1 : 5'd0;
      dec.rs2    = rs2_use ? rs2 : 5'd0;
      dec.fn3    = rs1_use ? fn3 : 3'd0;
      dec.fn7    = ((fmt == FMT_R) || shift_op) ? fn7 : 7'd0;
      dec.rs1_en = rs1_use;
      dec.rs2_en = rs2_use;
      dec.rd_we  = rd_use && (rd != 5'd0);
      case (fmt)
        FMT_I:   imm = imm_i;
        FMT_S:   imm = imm_s;
        FMT_B:   imm = imm_b;
        FMT_U:   imm = imm_u;
        FMT_J:   imm = imm_j;
        default: imm = '0;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: decodes on the input path and holds results in an
// output register backed by a one-entry skid register (XLEN must be 32 or 64).
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter bit RVE   = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_fn3,
  output logic [6:0]       out_fn7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_rs1_en,
  output logic             out_rs2_en,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_t             dec_in;
  logic [XLEN-1:0]  imm_in;
  dec_t             out_reg;
  dec_t             skid_reg;
  logic [XLEN-1:0]  out_imm_reg;
  logic [XLEN-1:0]  skid_imm_reg;
  logic [PC_W-1:0]  out_pc_reg;
  logic [PC_W-1:0]  skid_pc_reg;
  skid_state_e      state_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_xfer;
  logic             out_xfer;

  decode_logic #(
    .XLEN (XLEN),
    .RVE  (RVE)
  ) u_decode (
    .inst (in_inst),
    .dec  (dec_in),
    .imm  (imm_in)
  );

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      out_imm_reg   <= '0;
      out_pc_reg    <= '0;
      skid_reg      <= '0;
      skid_imm_reg  <= '0;
      skid_pc_reg   <= '0;
    end else if (flush) begin
      // Flush wins over any same-cycle input transfer; held data is simply invalidated.
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          in_ready_reg <= 1'b1;
          if (in_xfer) begin
            out_reg       <= dec_in;
            out_imm_reg   <= imm_in;
            out_pc_reg    <= in_pc;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            out_reg     <= dec_in;
            out_imm_reg <= imm_in;
            out_pc_reg  <= in_pc;
          end else if (out_xfer) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_EMPTY;
          end else if (in_xfer) begin
            skid_reg     <= dec_in;
            skid_imm_reg <= imm_in;
            skid_pc_reg  <= in_pc;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            out_reg      <= skid_reg;
            out_imm_reg  <= skid_imm_reg;
            out_pc_reg   <= skid_pc_reg;
            in_ready_reg <= 1'b1;
            state_reg    <= ST_FULL;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Counts illegal instructions actually handed downstream; saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (out_xfer && out_reg.illegal && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_opcode  = out_reg.opcode;
  assign out_rd      = out_reg.rd;
  assign out_rs1     = out_reg.rs1;
  assign out_rs2     = out_reg.rs2;
  assign out_fn3     = out_reg.fn3;
  assign out_fn7     = out_reg.fn7;
  assign out_fmt     = out_reg.fmt;
  assign out_rs1_en  = out_reg.rs1_en;
  assign out_rs2_en  = out_reg.rs2_en;
  assign out_rd_we   = out_reg.rd_we;
  assign out_illegal = out_reg.illegal;
  assign out_imm     = out_imm_reg;
  assign out_pc      = out_pc_reg;
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (base, and RVE with a 2-bit counter)
// driven in lockstep and checked every cycle against a queue-based model.
module tb_decode_stage;

  localparam int NV = 2;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;

  logic        d_rdy [NV];
  logic        d_ov  [NV];
  logic        d_r1e [NV];
  logic        d_r2e [NV];
  logic        d_we  [NV];
  logic        d_ill [NV];
  logic [6:0]  d_opc [NV];
  logic [6:0]  d_f7  [NV];
  logic [4:0]  d_rd  [NV];
  logic [4:0]  d_rs1 [NV];
  logic [4:0]  d_rs2 [NV];
  logic [2:0]  d_f3  [NV];
  logic [2:0]  d_fmt [NV];
  logic [31:0] d_imm [NV];
  logic [31:0] d_pc  [NV];
  logic [15:0] d_cnt [NV];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NV; gi++) begin : g_dut
    localparam int CW = (gi == 0) ? 16 : 2;
    logic [CW-1:0] cnt_w;
    decode_stage #(
      .XLEN  (32),
      .PC_W  (32),
      .RVE   (gi == 1),
      .CNT_W (CW)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (d_rdy[gi]),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .out_valid   (d_ov[gi]),
      .out_ready   (out_ready),
      .out_opcode  (d_opc[gi]),
      .out_rd      (d_rd[gi]),
      .out_rs1     (d_rs1[gi]),
      .out_rs2     (d_rs2[gi]),
      .out_fn3     (d_f3[gi]),
      .out_fn7     (d_f7[gi]),
      .out_imm     (d_imm[gi]),
      .out_fmt     (d_fmt[gi]),
      .out_rs1_en  (d_r1e[gi]),
      .out_rs2_en  (d_r2e[gi]),
      .out_rd_we   (d_we[gi]),
      .out_illegal (d_ill[gi]),
      .out_pc      (d_pc[gi]),
      .illegal_cnt (cnt_w)
    );
    assign d_cnt[gi] = 16'(cnt_w);
  end

  task automatic chk(string name, int v, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, v, $time, act, exp);
  endtask

  // Reference decode straight from the ISA tables; fn7 is reported for R-type
  // and for shift-immediates, unused fields read as zero, illegal words keep only opcode.
  function automatic exp_t model_dec(logic [31:0] w, bit rve);
    exp_t        e;
    int          f;
    bit          ok;
    bit          shamt;
    bit          u_rd;
    bit          u_rs1;
    bit          u_rs2;
    logic [31:0] sgn;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    sgn = {32{w[31]}};
    e = '0;
    e.opcode = op;
    ok = 1'b1;
    shamt = 1'b0;
    case (op)
      7'h37, 7'h17: f = 4;
      7'h6f: f = 5;
      7'h67: begin f = 1; ok = (f3 == 0); end
      7'h03: begin f = 1; ok = !(f3 == 3 || f3 == 6 || f3 == 7); end
      7'h13: begin
        f = 1;
        shamt = (f3 == 1 || f3 == 5);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
      end
      7'h23: begin f = 2; ok = (f3 <= 2); end
      7'h63: begin f = 3; ok = !(f3 == 2 || f3 == 3); end
      7'h33: begin f = 0; ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
      default: begin f = 7; ok = 1'b0; end
    endcase
    u_rd  = (f == 0 || f == 1 || f == 4 || f == 5);
    u_rs1 = (f <= 3);
    u_rs2 = (f == 0 || f == 2 || f == 3);
    if (rve && ((u_rd && w[11:7] >= 16) || (u_rs1 && w[19:15] >= 16) || (u_rs2 && w[24:20] >= 16)))
      ok = 1'b0;
    if (!ok) begin
      e.fmt = 3'd7;
      e.illegal = 1'b1;
      return e;
    end
    e.fmt = 3'(f);
    if (u_rd)  e.rd  = w[11:7];
    if (u_rs1) e.rs1 = w[19:15];
    if (u_rs2) e.rs2 = w[24:20];
    if (u_rs1) e.fn3 = f3;
    if (f == 0 || shamt) e.fn7 = f7;
    e.rs1_en = u_rs1;
    e.rs2_en = u_rs2;
    e.rd_we = u_rd && (w[11:7] != 0);
    case (f)
      1: e.imm = (sgn << 12) | 32'(w[31:20]);
      2: e.imm = (sgn << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
      3: e.imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      4: e.imm = w & 32'hFFFF_F000;
      5: e.imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: e.imm = '0;
    endcase
    return e;
  endfunction

  function automatic exp_t act_of(int v);
    exp_t a;
    a.opcode  = d_opc[v];
    a.rd      = d_rd[v];
    a.rs1     = d_rs1[v];
    a.rs2     = d_rs2[v];
    a.fn3     = d_f3[v];
    a.fn7     = d_f7[v];
    a.fmt     = d_fmt[v];
    a.imm     = d_imm[v];
    a.rs1_en  = d_r1e[v];
    a.rs2_en  = d_r2e[v];
    a.rd_we   = d_we[v];
    a.illegal = d_ill[v];
    return a;
  endfunction

  function automatic int cmax(int v);
    return (v == 0) ? 65535 : 3;
  endfunction

  // Flow model: the stage is a two-deep FIFO whose ready is registered.
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  bit          exp_in_ready = 1'b0;
  int          exp_cnt [NV];
  bit          ix;
  bit          ox;
  exp_t        head_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_inst.delete();
      q_pc.delete();
      exp_in_ready = 1'b0;
      for (int v = 0; v < NV; v++) exp_cnt[v] = 0;
    end else begin
      ix = in_valid && exp_in_ready;
      ox = (q_inst.size() > 0) && out_ready;
      if (ox) begin
        for (int v = 0; v < NV; v++) begin
          head_e = model_dec(q_inst[0], v == 1);
          if (head_e.illegal && exp_cnt[v] < cmax(v)) exp_cnt[v]++;
        end
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
      end
      if (flush) begin
        q_inst.delete();
        q_pc.delete();
      end else if (ix) begin
        q_inst.push_back(in_inst);
        q_pc.push_back(in_pc);
      end
      exp_in_ready = (q_inst.size() < 2);
    end
  end

  always @(negedge clk) begin
    for (int v = 0; v < NV; v++) begin
      if (!rst_n) begin
        chk("reset_state", v, {d_rdy[v], d_ov[v], d_cnt[v], d_pc[v], act_of(v)}, '0);
      end else begin
        chk("in_ready", v, d_rdy[v], exp_in_ready);
        chk("out_valid", v, d_ov[v], q_inst.size() > 0);
        chk("illegal_cnt", v, d_cnt[v], exp_cnt[v]);
        if (q_inst.size() > 0) begin
          chk("decode", v, act_of(v), model_dec(q_inst[0], v == 1));
          chk("out_pc", v, d_pc[v], q_pc[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] w, logic [31:0] p);
    in_valid = 1'b1;
    in_inst  = w;
    in_pc    = p;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33};
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 9);
    if (k < 9) w[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    exp_t e;
    // Hand-derived decodes that pin the model itself.
    e = '{opcode: 7'h13, rd: 5'd1, rs1: 5'd2, rs2: 5'd0, fn3: 3'd0, fn7: 7'd0, fmt: 3'd1,
          imm: 32'hFFFF_FFFF, rs1_en: 1'b1, rs2_en: 1'b0, rd_we: 1'b1, illegal: 1'b0};
    chk("model_addi", 0, model_dec(32'hFFF1_0093, 1'b0), e);
    e = '{opcode: 7'h6f, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, fn3: 3'd0, fn7: 7'd0, fmt: 3'd5,
          imm: 32'h0000_0800, rs1_en: 1'b0, rs2_en: 1'b0, rd_we: 1'b0, illegal: 1'b0};
    chk("model_jal", 0, model_dec(32'h0010_006F, 1'b0), e);
    e = '{opcode: 7'h63, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, fn3: 3'd0, fn7: 7'd0, fmt: 3'd3,
          imm: 32'h0000_0010, rs1_en: 1'b1, rs2_en: 1'b1, rd_we: 1'b0, illegal: 1'b0};
    chk("model_beq", 0, model_dec(32'h0020_8863, 1'b0), e);

    tick();
    tick();
    chk("rst_in_ready", 0, d_rdy[0], 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 0, d_rdy[0], 1'b1);

    // ADDI x1,x2,-1 with one-cycle latency
    out_ready = 1'b1;
    drive(32'hFFF1_0093, 32'h100);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", 0, d_ov[0], 1'b1);
    chk("addi_regs", 0, {d_rd[0], d_rs1[0]}, {5'd1, 5'd2});
    chk("addi_imm", 0, d_imm[0], 32'hFFFF_FFFF);
    chk("addi_fmt_we", 0, {d_fmt[0], d_we[0]}, {3'd1, 1'b1});
    tick();

    // JAL x0,+2048
    drive(32'h0010_006F, 32'h104);
    tick();
    in_valid = 1'b0;
    chk("jal_fmt", 0, d_fmt[0], 3'd5);
    chk("jal_imm", 0, d_imm[0], 32'h0000_0800);
    chk("jal_we_ill", 0, {d_we[0], d_ill[0]}, 2'b00);
    tick();

    // Three back-to-back instructions against a stalled consumer
    out_ready = 1'b0;
    drive(32'h0020_81B3, 32'h200);
    tick();
    drive(32'h0020_A423, 32'h204);
    tick();
    chk("skid_ready_low", 0, d_rdy[0], 1'b0);
    chk("skid_head_pc", 0, d_pc[0], 32'h200);
    drive(32'h0020_8863, 32'h208);
    out_ready = 1'b1;
    tick();
    chk("drain_pc1", 0, d_pc[0], 32'h204);
    chk("drain_ready", 0, d_rdy[0], 1'b1);
    tick();
    in_valid = 1'b0;
    chk("drain_pc2", 0, d_pc[0], 32'h208);
    tick();
    chk("drain_empty", 0, d_ov[0], 1'b0);

    // Illegal words and counter saturation on the 2-bit counter
    drive(32'h0000_0000, 32'h300);
    tick();
    chk("zero_illegal", 0, {d_ill[0], d_fmt[0], d_we[0]}, {1'b1, 3'd7, 1'b0});
    drive(32'h4231_00B3, 32'h304);
    tick();
    in_valid = 1'b0;
    chk("sub_bad_fn7", 0, d_ill[0], 1'b1);
    tick();
    tick();
    chk("cnt_two", 0, d_cnt[0], 16'd2);
    chk("cnt_two", 1, d_cnt[1], 16'd2);
    drive(32'hFFFF_FFFF, 32'h308);
    tick();
    drive(32'h0000_3003, 32'h30C);
    tick();
    drive(32'h0000_3023, 32'h310);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("cnt_five", 0, d_cnt[0], 16'd5);
    chk("cnt_sat", 1, d_cnt[1], 16'd3);

    // ADD x16,x1,x2 is legal normally, illegal with RVE
    out_ready = 1'b0;
    drive(32'h0020_8833, 32'h400);
    tick();
    in_valid = 1'b0;
    chk("rve_illegal", 1, {d_ill[1], d_we[1]}, 2'b10);
    chk("base_add_x16", 0, {d_ill[0], d_we[0], d_rd[0]}, {1'b0, 1'b1, 5'd16});
    out_ready = 1'b1;
    tick();
    tick();

    // Flush while in SKID with a pending input
    out_ready = 1'b0;
    drive(32'h0020_81B3, 32'h500);
    tick();
    drive(32'h0020_A423, 32'h504);
    tick();
    drive(32'h0020_8863, 32'h508);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 0, d_ov[0], 1'b0);
    chk("flush_ready", 0, d_rdy[0], 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_no_emit", 0, d_ov[0], 1'b0);
    chk("flush_cnt", 1, d_cnt[1], 16'd3);

    // Randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_inst   = rand_inst();
      in_pc     = $urandom();
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
